weight_stream_neuron: RTL and testbench

- Consumer end of the weight stream produced by the weight ROM/RAM streamer. Accepts one weight per beat with no backpressure, pairs each weight with an activation, and runs a fixed-point multiply-accumulate over NO_OF_WEIGHT pairs.
- At the end of each pass it adds the bias, saturates, optionally applies ReLU, and emits one result beat. It is one neuron of a fully connected layer.

---
 rtl/weight_stream_neuron_pkg.sv | 25 ++
 rtl/weight_stream_neuron_fifo.sv | 49 ++++
 rtl/weight_stream_neuron.sv | 142 ++++++++++++++
 tb/tb_weight_stream_neuron.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_neuron_pkg.sv
// Shared types and fixed-point helpers for the weight-stream neuron.
package neuron_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, FINAL} state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FRAC_BITS  = 16;
    localparam logic [DEF_DATA_WIDTH-1:0] Q_SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    localparam logic [DEF_DATA_WIDTH-1:0] Q_SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

    // Working width for saturation; must exceed the accumulator width plus one.
    localparam int unsigned SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] v,
                                                           input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/weight_stream_neuron_fifo.sv
// Synchronous weight FIFO, first-word-fall-through read, power-of-2 depth.
module weight_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [CW-1:0]         r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/weight_stream_neuron.sv
// One fully-connected neuron: streamed weights x activations, MAC, bias, saturate, optional ReLU.
module weight_stream_neuron
    import neuron_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS    = DEF_FRAC_BITS,
    parameter int unsigned NO_OF_WEIGHT = 784,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned RELU_EN      = 1,
    parameter int unsigned CNT_WIDTH    = $clog2(NO_OF_WEIGHT+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  x_tvalid,
    input  logic [DATA_WIDTH-1:0] x_tdata,
    output logic                  x_tready,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  busy,
    output logic                  err_overflow
);
    localparam int unsigned PW    = 2*DATA_WIDTH;
    localparam int unsigned ACC_W = PW + CNT_WIDTH;
    localparam int unsigned FW    = $clog2(FIFO_DEPTH+1);

    state_t                  r_state;
    logic                    r_drain;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic signed [PW-1:0]    r_prod;
    logic                    r_prod_vld;
    logic signed [ACC_W-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_bias;
    logic [DATA_WIDTH-1:0]   r_mdata;
    logic                    r_mvalid;
    logic                    r_busy;
    logic                    r_ovf;

    logic                    w_full;
    logic                    w_empty;
    logic [FW-1:0]           w_count;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_fire;
    logic                    w_push;
    logic signed [PW-1:0]    w_w_ext;
    logic signed [PW-1:0]    w_x_ext;
    logic signed [ACC_W:0]   w_bias_ext;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_shift;
    logic signed [SAT_W-1:0] w_sat_in;
    logic [DATA_WIDTH-1:0]   w_narrow;
    logic [DATA_WIDTH-1:0]   w_result;

    assign x_tready = (r_state == ACCUM) && !w_empty;
    assign w_fire   = x_tvalid && x_tready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the beat.
    assign w_push   = s_axis_tvalid && (!w_full || w_fire);

    weight_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (s_axis_tdata),
        .i_pop   (w_fire),
        .o_rdata (w_wdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_w_ext    = {{DATA_WIDTH{w_wdata[DATA_WIDTH-1]}}, w_wdata};
    assign w_x_ext    = {{DATA_WIDTH{x_tdata[DATA_WIDTH-1]}}, x_tdata};
    assign w_bias_ext = {{(ACC_W+1-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + (w_bias_ext <<< FRAC_BITS);
    assign w_shift    = w_sum >>> FRAC_BITS;
    assign w_sat_in   = {{(SAT_W-ACC_W-1){w_shift[ACC_W]}}, w_shift};
    assign w_narrow   = DATA_WIDTH'(sat_narrow(w_sat_in, DATA_WIDTH));
    assign w_result   = ((RELU_EN != 0) && w_narrow[DATA_WIDTH-1]) ? '0 : w_narrow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ACCUM;
            r_drain    <= 1'b0;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_bias     <= '0;
            r_mdata    <= '0;
            r_mvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_prod_vld <= w_fire;
            if (w_fire) r_prod <= w_w_ext * w_x_ext;
            if (r_prod_vld) r_acc <= r_acc + {{CNT_WIDTH{r_prod[PW-1]}}, r_prod};
            if (s_axis_tvalid && w_full && !w_fire) r_ovf <= 1'b1;
            if (w_fire)        r_busy <= 1'b1;
            else if (r_mvalid) r_busy <= 1'b0;
            r_mvalid <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_fire) begin
                        if (r_cnt == '0) r_bias <= bias;
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (r_cnt == CNT_WIDTH'(NO_OF_WEIGHT - 1)) begin
                            r_state <= DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) r_state <= FINAL;
                end
                FINAL: begin
                    r_mdata  <= w_result;
                    r_mvalid <= 1'b1;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_state  <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (w_count <= FW'(FIFO_DEPTH));
    end

    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tdata  = r_mdata;
    assign busy          = r_busy;
    assign err_overflow  = r_ovf;

endmodule

// File: tb/tb_weight_stream_neuron.sv
// Scoreboard bench: DUT 0 (depth 8, ReLU on) and DUT 1 (depth 4, ReLU off), 4 pairs per pass.
module tb_weight_stream_neuron;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_v   [2];
    logic [31:0] s_d   [2];
    logic        x_v   [2];
    logic [31:0] x_d   [2];
    logic [31:0] b     [2];
    logic        x_rdy [2];
    logic        m_v   [2];
    logic [31:0] m_d   [2];
    logic        bsy   [2];
    logic        ovf   [2];

    logic [31:0] pw [8];
    logic [31:0] px [8];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_fire [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    weight_stream_neuron #(.DATA_WIDTH(32), .FRAC_BITS(16), .NO_OF_WEIGHT(NW),
                           .FIFO_DEPTH(8), .RELU_EN(1)) u_relu (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_v[0]), .s_axis_tdata(s_d[0]),
        .x_tvalid(x_v[0]), .x_tdata(x_d[0]), .x_tready(x_rdy[0]),
        .bias(b[0]), .m_axis_tvalid(m_v[0]), .m_axis_tdata(m_d[0]),
        .busy(bsy[0]), .err_overflow(ovf[0]));

    weight_stream_neuron #(.DATA_WIDTH(32), .FRAC_BITS(16), .NO_OF_WEIGHT(NW),
                           .FIFO_DEPTH(4), .RELU_EN(0)) u_lin (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_v[1]), .s_axis_tdata(s_d[1]),
        .x_tvalid(x_v[1]), .x_tdata(x_d[1]), .x_tready(x_rdy[1]),
        .bias(b[1]), .m_axis_tvalid(m_v[1]), .m_axis_tdata(m_d[1]),
        .busy(bsy[1]), .err_overflow(ovf[1]));

    // Reference: exact wide MAC, bias in Q16, floor shift, clamp, optional ReLU.
    function automatic logic [31:0] ref_model(input int base, input logic [31:0] bv, input bit relu);
        logic signed [127:0] acc, t, hi, lo, bt;
        logic signed [63:0]  a64, x64, p;
        logic [31:0]         r;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            a64 = {{32{pw[base+i][31]}}, pw[base+i]};
            x64 = {{32{px[base+i][31]}}, px[base+i]};
            p   = a64 * x64;
            acc = acc + {{64{p[63]}}, p};
        end
        bt = {{96{bv[31]}}, bv};
        t  = acc + (bt <<< 16);
        t  = t >>> 16;
        hi = 128'sh7FFF_FFFF;
        lo = ~hi;
        if (t > hi)      r = 32'h7FFF_FFFF;
        else if (t < lo) r = 32'h8000_0000;
        else             r = t[31:0];
        if (relu && r[31]) r = '0;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && m_v[0]) begin
            n_checks++;
            if (q0.size() == 0) $display("FAIL dut0_result: got %h, none expected", m_d[0]);
            else begin
                e = q0.pop_front();
                if (m_d[0] !== e) $display("FAIL dut0_result: got %h, expected %h", m_d[0], e);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && m_v[1]) begin
            n_checks++;
            if (q1.size() == 0) $display("FAIL dut1_result: got %h, none expected", m_d[1]);
            else begin
                e = q1.pop_front();
                if (m_d[1] !== e) $display("FAIL dut1_result: got %h, expected %h", m_d[1], e);
                else n_pass++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_weights(input int d, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            s_v[d] = 1'b1;
            s_d[d] = pw[base+i];
            tick();
        end
        s_v[d] = 1'b0;
    endtask

    task automatic send_x(input int d, input int base, input int n, output bit ok);
        int  i;
        int  guard;
        bit  fired;
        i = 0;
        guard = 0;
        x_d[d] = px[base];
        x_v[d] = 1'b1;
        while (i < n && guard < 200) begin
            @(negedge clk);
            fired = x_v[d] && x_rdy[d];
            if (fired) last_fire[d] = cyc;
            tick();
            guard++;
            if (fired) begin
                i++;
                if (i < n) x_d[d] = px[base+i];
                else       x_v[d] = 1'b0;
            end
        end
        x_v[d] = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_results(input int d, output bit ok);
        for (int k = 0; k < 40; k++) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) break;
            @(negedge clk);
        end
        tick();
        ok = ((d == 0 ? q0.size() : q1.size()) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (x_rdy[d] !== 1'b0) $display("FAIL reset_x_tready%0d: got %b, expected 0", d, x_rdy[d]);
            else n_pass++;
            n_checks++;
            if ({m_v[d], bsy[d], ovf[d]} !== 3'b000)
                $display("FAIL reset_flags%0d: got %b, expected 000", d, {m_v[d], bsy[d], ovf[d]});
            else n_pass++;
            n_checks++;
            if (m_d[d] !== 32'h0) $display("FAIL reset_tdata%0d: got %h, expected 0", d, m_d[d]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int seen;
        bit busy_at;
        for (int i = 0; i < NW; i++) begin pw[i] = 32'h0001_0000; px[i] = 32'h0002_0000; end
        b[0] = 32'h0000_8000;
        b[1] = 32'h0000_8000;
        q0.push_back(32'h0008_8000);
        send_weights(0, 0, NW);
        send_x(0, 0, NW, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_x_accept: got timeout, expected %0d pairs", NW); else n_pass++;
        seen = -1;
        busy_at = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_v[0]) begin seen = cyc; busy_at = bsy[0]; break; end
        end
        n_checks++;
        if (seen != last_fire[0] + 4)
            $display("FAIL basic_latency: got cycle %0d, expected %0d", seen, last_fire[0] + 4);
        else n_pass++;
        n_checks++;
        if (busy_at !== 1'b1) $display("FAIL basic_busy_at_result: got %b, expected 1", busy_at); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (m_v[0] !== 1'b0) $display("FAIL basic_single_pulse: got %b, expected 0", m_v[0]); else n_pass++;
        n_checks++;
        if (m_d[0] !== 32'h0008_8000) $display("FAIL basic_hold: got %h, expected 00088000", m_d[0]); else n_pass++;
        n_checks++;
        if (bsy[0] !== 1'b0) $display("FAIL basic_busy_after: got %b, expected 0", bsy[0]); else n_pass++;
        tick();
        q1.push_back(32'h0008_8000);
        send_weights(1, 0, NW);
        send_x(1, 0, NW, ok);
        wait_results(1, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_dut1_done: got result missing, expected result"); else n_pass++;
    endtask

    task automatic test_relu();
        bit ok;
        for (int i = 0; i < NW; i++) begin pw[i] = 32'hFFFF_0000; px[i] = 32'h0002_0000; end
        b[0] = '0;
        b[1] = '0;
        q0.push_back(32'h0000_0000);
        q1.push_back(32'hFFF8_0000);
        for (int d = 0; d < 2; d++) begin
            send_weights(d, 0, NW);
            send_x(d, 0, NW, ok);
            wait_results(d, ok);
            n_checks++;
            if (!ok) $display("FAIL relu_done%0d: got result missing, expected result", d); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        bit ok;
        for (int i = 0; i < NW; i++) begin pw[i] = 32'h7FFF_0000; px[i] = 32'h7FFF_0000; end
        q0.push_back(32'h7FFF_FFFF);
        send_weights(0, 0, NW);
        send_x(0, 0, NW, ok);
        wait_results(0, ok);
        n_checks++;
        if (!ok) $display("FAIL sat_pos_done: got result missing, expected result"); else n_pass++;
        for (int i = 0; i < NW; i++) pw[i] = 32'h8001_0000;
        q1.push_back(32'h8000_0000);
        send_weights(1, 0, NW);
        send_x(1, 0, NW, ok);
        wait_results(1, ok);
        n_checks++;
        if (!ok) $display("FAIL sat_neg_done: got result missing, expected result"); else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        pw[0] = 32'h0001_0000; pw[1] = 32'h0002_0000; pw[2] = 32'h0003_0000;
        pw[3] = 32'h0004_0000; pw[4] = 32'h0064_0000;
        for (int i = 0; i < NW; i++) px[i] = 32'h0001_0000;
        b[1] = '0;
        send_weights(1, 0, NW);
        @(negedge clk);
        n_checks++;
        if (ovf[1] !== 1'b0) $display("FAIL ovf_at_full: got %b, expected 0", ovf[1]); else n_pass++;
        tick();
        send_weights(1, 4, 1);
        @(negedge clk);
        n_checks++;
        if (ovf[1] !== 1'b1) $display("FAIL ovf_on_drop: got %b, expected 1", ovf[1]); else n_pass++;
        tick();
        q1.push_back(32'h000A_0000);
        send_x(1, 0, NW, ok);
        wait_results(1, ok);
        n_checks++;
        if (!ok) $display("FAIL ovf_pass_done: got result missing, expected result"); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (x_rdy[1] !== 1'b0) $display("FAIL ovf_fifo_drained: got x_tready %b, expected 0", x_rdy[1]); else n_pass++;
        n_checks++;
        if (ovf[1] !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", ovf[1]); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit xok;
        for (int i = 0; i < 8; i++) begin
            pw[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
            px[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
        end
        b[0] = $urandom_range(0, 32'h0002_0000) - 32'h0001_0000;
        q0.push_back(ref_model(0, b[0], 1'b1));
        q0.push_back(ref_model(4, b[0], 1'b1));
        xok = 1'b0;
        fork
            send_weights(0, 0, 8);
            begin : xdrv
                int  i;
                int  guard;
                bit  fired;
                i = 0;
                guard = 0;
                x_d[0] = px[0];
                x_v[0] = ($urandom_range(0, 1) == 1);
                while (i < 8 && guard < 400) begin
                    @(negedge clk);
                    fired = x_v[0] && x_rdy[0];
                    tick();
                    guard++;
                    if (fired) begin
                        i++;
                        if (i < 8) x_d[0] = px[i];
                        if (i == 4 || i == 8) begin
                            for (int k = 0; k < 3; k++) begin
                                @(negedge clk);
                                n_checks++;
                                if (x_rdy[0] !== 1'b0)
                                    $display("FAIL b2b_tready_drain: got %b at drain cycle %0d, expected 0", x_rdy[0], k);
                                else n_pass++;
                                tick();
                            end
                        end
                    end
                    x_v[0] = (i < 8) ? ($urandom_range(0, 1) == 1) : 1'b0;
                end
                x_v[0] = 1'b0;
                xok = (i == 8);
            end
        join
        n_checks++;
        if (!xok) $display("FAIL b2b_x_accept: got timeout, expected 8 pairs"); else n_pass++;
        wait_results(0, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_done: got %0d results pending, expected 0", q0.size()); else n_pass++;
        n_checks++;
        if (ovf[0] !== 1'b0) $display("FAIL b2b_no_overflow: got %b, expected 0", ovf[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        int pulses;
        for (int i = 0; i < NW; i++) begin pw[i] = 32'h0005_0000; px[i] = 32'h0003_0000; end
        b[0] = 32'h0001_0000;
        send_weights(0, 0, NW);
        send_x(0, 0, 2, ok);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bsy[0] !== 1'b0) $display("FAIL midreset_busy: got %b, expected 0", bsy[0]); else n_pass++;
        n_checks++;
        if ({ovf[0], ovf[1]} !== 2'b00) $display("FAIL midreset_overflow: got %b, expected 00", {ovf[0], ovf[1]}); else n_pass++;
        n_checks++;
        if (x_rdy[0] !== 1'b0) $display("FAIL midreset_flushed: got x_tready %b, expected 0", x_rdy[0]); else n_pass++;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_v[0]) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 0) $display("FAIL midreset_no_result: got %0d pulses, expected 0", pulses); else n_pass++;
        tick();
        for (int i = 0; i < NW; i++) begin pw[i] = 32'h0000_8000; px[i] = 32'h0003_0000; end
        b[0] = 32'hFFFF_0000;
        q0.push_back(32'h0005_0000);
        send_weights(0, 0, NW);
        send_x(0, 0, NW, ok);
        wait_results(0, ok);
        n_checks++;
        if (!ok) $display("FAIL midreset_clean_done: got result missing, expected result"); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_v[d] = 1'b0; s_d[d] = '0; x_v[d] = 1'b0; x_d[d] = '0; b[d] = '0;
            last_fire[d] = 0;
        end
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_reset_mid_pass();
        repeat (5) tick();
        n_checks++;
        if (q0.size() + q1.size() != 0)
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", q0.size() + q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
